max_pool_2x2_stream: RTL and testbench
======================================

Name: max_pool_2x2_stream

Overview:
- Streaming 2x2, stride-2 max-pooling stage for the CNN datapath. Parametrised successor to the combinational two-row pooler.
- Accepts one pixel per beat (all D channels) in raster order over a W x H frame. Keeps horizontal pair maxima of each even row in an internal line buffer of W/2 entries.
- Emits one pooled pixel per 2x2 window through a registered valid/ready output. Sits between a conv/activation stage and the next conv layer.

Parameters:
- DATA_BITS, 32, bit width of one channel element (two's-complement signed).
- D, 32, channels per pixel.
- W, 92, input frame width in pixels; must be even and >= 2.
- H, 92, input frame height in rows; must be even and >= 2.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous frame abort; zeroes counters and output valid.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept beat.
- in_data  in  D*DATA_BITS  one pixel; channel c at [c*DATA_BITS +: DATA_BITS].
- out_valid  out  1  pooled pixel valid.
- out_ready  in  1  downstream accepts.
- out_data  out  D*DATA_BITS  pooled pixel, same channel packing.
- out_last  out  1  qualifies the final pooled pixel of a frame.

Behaviour:
- Reset (rst_n=0, async): out_valid=0, out_data=0, out_last=0, col=0, row=0, pair register=0. Line buffer contents are don't-care. in_ready is combinational: in_ready = !out_valid | out_ready.
- Beat accepted when in_valid & in_ready. Counters col (0..W-1) and row (0..H-1) advance per accepted beat. At col=W-1: col wraps to 0 and row increments. At col=W-1 and row=H-1: both wrap to 0 and the next frame starts with no idle cycle.
- Even col: latch in_data into pair register P.
- Odd col: horizontal max Hm[c] = max(P[c], in_data[c]) per channel, signed compare. Ties select either operand (equal value).
- Even row, odd col: write Hm into line buffer LB[col>>1]. No output.
- Odd row, odd col: out_data[c] <= max(Hm[c], LB[col>>1][c]). out_valid <= 1. out_last <= (row==H-1 & col==W-1).
- Latency: out_valid rises on the clock edge that accepts the window's last (bottom-right) beat, i.e. 1 cycle.
- Output hold: out_valid, out_data and out_last stay stable until out_valid & out_ready. They then clear unless a new window completes in the same cycle, in which case they reload (back-to-back allowed).
- Backpressure: while out_valid & !out_ready, in_ready=0 and no beat is consumed. This includes non-producing beats, which simplifies the hold rule.
- Throughput: one input beat per cycle sustained when out_ready=1. Output rate is 1/4 of input rate.
- clear=1: synchronously sets col=0, row=0, out_valid=0 and out_last=0, and discards the partial frame. Any in-flight beat in that cycle is ignored. clear has priority over acceptance.
- Reset mid-frame: same as clear, but asynchronous.
- Width rule: no widening. Output element width is DATA_BITS.
- Elaboration: an odd W or H, or a value < 2, is a fatal $error.

Optional Feature:
- Macro MAXPOOL_RELU_EN.
- Defined: each output channel is clamped to 0 when negative (fused ReLU). The clamp is applied at the output register load, so latency is unchanged.
- Undefined: raw signed maxima are output.
- Pooling maxima are computed identically in both cases.

Decomposition:
- Package maxpool_pkg: localparam helpers CLOG2-based widths for col/row/LB address, and a function smax(a,b) for the signed DATA_BITS compare.
- Sub-module maxpool_lane_max: D-lane parallel signed max of two D*DATA_BITS vectors. Instanced twice, once for the horizontal max and once for the vertical max.
- Line buffer: inferred register/RAM array, W/2 x D*DATA_BITS, one write port and one read port, same-cycle read of the address written on the previous row.

Test Plan:
- W=4,H=2,D=2,DATA_BITS=8, row0 ch0 = {1,5,-3,2}, row1 ch0 = {4,0,7,-8}, in_valid=1 continuous, out_ready=1 -> two outputs ch0 = 5 then 7. out_valid is asserted 1 cycle after beats 5 and 7; out_last=1 on the second only.
- Same frame, all values negative: ch0 rows {-9,-2,-5,-6} / {-4,-3,-1,-7} -> ch0 = -2, -1 without MAXPOOL_RELU_EN; 0, 0 with it.
- out_ready held 0 for 5 cycles after the first output -> out_data stays 5, in_ready=0, and no counter advance. After release the second output is still 7.
- W=4,H=4, two back-to-back frames, 32 beats with no gap -> 8 outputs; out_last on outputs 4 and 8; the frame-2 window uses only frame-2 data.
- clear pulsed after 3 beats, then a full fresh frame -> no output from the partial data; results match the golden model for the fresh frame.
- rst_n asserted mid-row of row 1 -> out_valid drops immediately (async); the next frame pools correctly from row 0.

Source files
------------

// File: rtl/max_pool_2x2_stream_pkg.sv
// Shared types and helpers for the 2x2 stride-2 streaming max-pool stage.
// Provides counter/address width helpers, the beat classification enum and the signed lane max.
package maxpool_pkg;

  // Widest channel element the signed compare helper accepts.
  localparam int MAX_DATA_BITS = 64;

  // Role of an accepted beat, decoded from the parity of its column and row.
  typedef enum logic [1:0] {
    BEAT_PAIR,   // even column: hold the pixel as the left half of a pair
    BEAT_STORE,  // even row, odd column: park the pair maximum in the line buffer
    BEAT_EMIT    // odd row, odd column: finish a 2x2 window
  } beat_kind_e;

  // Width of a counter or address able to hold the values 0..n-1 (never zero bits).
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Signed maximum; callers sign-extend narrower elements to MAX_DATA_BITS first.
  function automatic logic signed [MAX_DATA_BITS-1:0] smax(
    input logic signed [MAX_DATA_BITS-1:0] a,
    input logic signed [MAX_DATA_BITS-1:0] b
  );
    return (a >= b) ? a : b;
  endfunction

endpackage

// File: rtl/max_pool_2x2_stream_if.sv
// Pixel stream interface of the max-pool stage: input beats in, pooled pixels out.
// The slave modport is the pooling block's view; the master modport is the neighbouring stages' view.
interface max_pool_2x2_stream_if #(
  parameter int DATA_BITS = 32,
  parameter int D         = 32
) ();

  logic                   in_valid;
  logic                   in_ready;
  logic [D*DATA_BITS-1:0] in_data;

  logic                   out_valid;
  logic                   out_ready;
  logic [D*DATA_BITS-1:0] out_data;
  logic                   out_last;

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_last
  );

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_last
  );

endinterface

// File: rtl/max_pool_2x2_stream_lane_max.sv
// D-lane parallel signed maximum of two packed pixel vectors (channel c at [c*DATA_BITS +: DATA_BITS]).
// Purely combinational; used for both the horizontal and the vertical reduction.
module maxpool_lane_max
  import maxpool_pkg::*;
#(
  parameter int DATA_BITS = 32,
  parameter int D         = 32
) (
  input  logic [D*DATA_BITS-1:0] a,
  input  logic [D*DATA_BITS-1:0] b,
  output logic [D*DATA_BITS-1:0] y
);

  if (DATA_BITS < 1 || DATA_BITS > MAX_DATA_BITS) begin : g_bad_bits
    $error("maxpool_lane_max: DATA_BITS=%0d outside 1..%0d", DATA_BITS, MAX_DATA_BITS);
  end

  for (genvar c = 0; c < D; c++) begin : g_lane
    logic signed [DATA_BITS-1:0]     a_c;
    logic signed [DATA_BITS-1:0]     b_c;
    logic signed [MAX_DATA_BITS-1:0] a_x;
    logic signed [MAX_DATA_BITS-1:0] b_x;

    assign a_c = a[c*DATA_BITS +: DATA_BITS];
    assign b_c = b[c*DATA_BITS +: DATA_BITS];
    // Sized casts of signed operands sign-extend, so the wide compare keeps two's-complement order.
    assign a_x = MAX_DATA_BITS'(a_c);
    assign b_x = MAX_DATA_BITS'(b_c);
    assign y[c*DATA_BITS +: DATA_BITS] = DATA_BITS'(smax(a_x, b_x));
  end

endmodule

// File: rtl/max_pool_2x2_stream.sv
// Streaming 2x2 stride-2 max-pool over a W x H raster frame, one D-channel pixel per beat.
// Define MAXPOOL_RELU_EN to clamp negative pooled channels to zero at the output register.
module max_pool_2x2_stream
  import maxpool_pkg::*;
#(
  parameter int DATA_BITS = 32,
  parameter int D         = 32,
  parameter int W         = 92,
  parameter int H         = 92
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  max_pool_2x2_stream_if.slave bus
);

  localparam int VW       = D * DATA_BITS;
  localparam int COL_W    = cnt_w(W);
  localparam int ROW_W    = cnt_w(H);
  localparam int LB_DEPTH = W / 2;
  localparam int LB_AW    = cnt_w(LB_DEPTH);

  if (W < 2 || (W % 2) != 0) begin : g_bad_w
    $error("max_pool_2x2_stream: W=%0d must be even and >= 2", W);
  end
  if (H < 2 || (H % 2) != 0) begin : g_bad_h
    $error("max_pool_2x2_stream: H=%0d must be even and >= 2", H);
  end

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [VW-1:0]    pair_q;
  logic [VW-1:0]    hm;
  logic [VW-1:0]    vm;
  logic [VW-1:0]    lb_rd;
  logic [VW-1:0]    out_load;
  logic [VW-1:0]    lb [LB_DEPTH];
  logic [LB_AW-1:0] lb_addr;

  logic             out_valid_q;
  logic             out_last_q;
  logic [VW-1:0]    out_data_q;

  logic             in_ready;
  logic             accept;
  logic             at_last_col;
  logic             at_last_row;
  logic             frame_end;
  beat_kind_e       kind;

  // A held output blocks every beat, producing or not, so the output register never needs a skid slot.
  assign in_ready      = !out_valid_q || bus.out_ready;
  assign accept        = bus.in_valid && in_ready && !clear;
  assign at_last_col   = (col == COL_W'(W - 1));
  assign at_last_row   = (row == ROW_W'(H - 1));
  assign frame_end     = at_last_col && at_last_row;
  assign lb_addr       = LB_AW'(col >> 1);
  assign lb_rd         = lb[lb_addr];

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
    kind = BEAT_PAIR;
    if (col[0]) begin
      kind = row[0] ? BEAT_EMIT : BEAT_STORE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values, whatever the statement order.
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (clear) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (at_last_col) begin
        col <= '0;
        row <= at_last_row ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pair_q <= '0;
    end else if (accept && kind == BEAT_PAIR) begin
      pair_q <= bus.in_data;
    end
  end

  maxpool_lane_max #(
    .DATA_BITS (DATA_BITS),
    .D         (D)
  ) u_hmax (
    .a (pair_q),
    .b (bus.in_data),
    .y (hm)
  );

  // NOTE: the line buffer has no reset; each entry is rewritten on an even row before the odd row reads it.
  always_ff @(posedge clk) begin
    if (accept && kind == BEAT_STORE) begin
      lb[lb_addr] <= hm;
    end
  end

  maxpool_lane_max #(
    .DATA_BITS (DATA_BITS),
    .D         (D)
  ) u_vmax (
    .a (hm),
    .b (lb_rd),
    .y (vm)
  );

`ifdef MAXPOOL_RELU_EN
  always_comb begin
    out_load = vm;
    for (int c = 0; c < D; c++) begin
      if (vm[c*DATA_BITS + DATA_BITS - 1]) begin
        out_load[c*DATA_BITS +: DATA_BITS] = '0;
      end
    end
  end
`else
  assign out_load = vm;
`endif

  // A completing window reloads the register even while the previous pixel is being taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else if (clear) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else if (accept && kind == BEAT_EMIT) begin
      out_valid_q <= 1'b1;
      out_data_q  <= out_load;
      out_last_q  <= frame_end;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_max_pool_2x2_stream.sv
// Scoreboard bench for max_pool_2x2_stream: frames are modelled as plain arrays and every
// 2x2 window's expected result is queued at issue time, then checked by an independent monitor.
module tb_max_pool_2x2_stream;

  localparam int W       = 4;
  localparam int H       = 4;
  localparam int D       = 2;
  localparam int DB      = 8;
  localparam int VW      = D * DB;
  localparam int TIMEOUT = 400;

  typedef struct {
    logic [VW-1:0] data;
    logic          last;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;
  bit   rand_ready = 1'b0;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t exp_q[$];

  logic signed [DB-1:0] frame [H][W][D];

  max_pool_2x2_stream_if #(.DATA_BITS(DB), .D(D)) bus ();

  max_pool_2x2_stream #(
    .DATA_BITS (DB),
    .D         (D),
    .W         (W),
    .H         (H)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: maximum over the four pixels of the window whose bottom-right pixel is (r,c).
  function automatic logic [VW-1:0] pool_window(input int r, input int c);
    logic [VW-1:0] v;
    int m;
    v = '0;
    for (int ch = 0; ch < D; ch++) begin
      m = frame[r-1][c-1][ch];
      for (int dr = 0; dr < 2; dr++)
        for (int dc = 0; dc < 2; dc++)
          if (int'(frame[r-dr][c-dc][ch]) > m) m = frame[r-dr][c-dc][ch];
`ifdef MAXPOOL_RELU_EN
      if (m < 0) m = 0;
`endif
      v[ch*DB +: DB] = DB'(m);
    end
    return v;
  endfunction

  task automatic fill_random();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        for (int ch = 0; ch < D; ch++)
          frame[r][c][ch] = DB'($urandom);
  endtask

  // Directed channel-0 rows 0 and 1 over a random background.
  task automatic fill_plan(input bit negative);
    int row0 [W];
    int row1 [W];
    fill_random();
    if (negative) begin
      row0 = '{-9, -2, -5, -6};
      row1 = '{-4, -3, -1, -7};
    end else begin
      row0 = '{1, 5, -3, 2};
      row1 = '{4, 0, 7, -8};
    end
    for (int c = 0; c < W; c++) begin
      frame[0][c][0] = DB'(row0[c]);
      frame[1][c][0] = DB'(row1[c]);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the beat has been taken.
  task automatic send_beat(input int r, input int c);
    logic [VW-1:0] v;
    int waited;
    bit produces;
    produces = (r % 2 == 1) && (c % 2 == 1);
    for (int ch = 0; ch < D; ch++) v[ch*DB +: DB] = frame[r][c][ch];
    bus.in_valid = 1'b1;
    bus.in_data  = v;
    if (produces) exp_q.push_back('{pool_window(r, c), (r == H-1 && c == W-1)});
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!bus.in_ready && waited < TIMEOUT);
    if (!bus.in_ready) begin
      check("in_ready_timeout", 64'(bus.in_ready), 64'd1);
    end else begin
      @(posedge clk);
      #1;
      if (produces) check("latency_out_valid", 64'(bus.out_valid), 64'd1);
    end
  endtask

  task automatic send_frame(input bit gaps);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        if (gaps && $urandom_range(0, 3) == 0) begin
          bus.in_valid = 1'b0;
          @(posedge clk);
          #1;
        end
        send_beat(r, c);
      end
  endtask

  task automatic idle_and_drain();
    int waited;
    bus.in_valid = 1'b0;
    waited = 0;
    while (exp_q.size() != 0 && waited < TIMEOUT) begin
      @(posedge clk);
      waited++;
    end
    #1;
    check("drain_pending", 64'(exp_q.size()), 64'd0);
  endtask

  // Holds out_ready low for five cycles once the first output of the frame appears.
  task automatic stall_first_output();
    int waited;
    waited = 0;
    do begin
      @(posedge clk);
      #1;
      waited++;
    end while (!bus.out_valid && waited < TIMEOUT);
    check("stall_seen_output", 64'(bus.out_valid), 64'd1);
    bus.out_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("stall_out_data_ch0", 64'(bus.out_data[DB-1:0]), 64'(8'd5));
      check("stall_out_valid", 64'(bus.out_valid), 64'd1);
      check("stall_in_ready", 64'(bus.in_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
  endtask

  initial begin : ready_driver
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) bus.out_ready = ($urandom_range(0, 9) < 7);
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("out_data", 64'(bus.out_data), 64'(e.data));
          check("out_last", 64'(bus.out_last), 64'(e.last));
        end
      end
    end
  end

  initial begin : stimulus
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", 64'(bus.out_valid), 64'd0);
    check("reset_out_data", 64'(bus.out_data), 64'd0);
    check("reset_out_last", 64'(bus.out_last), 64'd0);
    check("reset_in_ready", 64'(bus.in_ready), 64'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed positive and all-negative windows, continuous input.
    fill_plan(1'b0);
    send_frame(1'b0);
    idle_and_drain();
    fill_plan(1'b1);
    send_frame(1'b0);
    idle_and_drain();

    // Backpressure on the first output of the frame.
    fill_plan(1'b0);
    fork
      send_frame(1'b0);
      stall_first_output();
    join
    idle_and_drain();

    // Two frames back to back with no idle beat between them.
    fill_random();
    send_frame(1'b0);
    fill_random();
    send_frame(1'b0);
    idle_and_drain();

    // Clear after three beats; the in-flight beat during clear must be ignored.
    fill_random();
    for (int c = 0; c < 3; c++) send_beat(0, c);
    bus.in_valid = 1'b1;
    bus.in_data  = VW'($urandom);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    bus.in_valid = 1'b0;
    check("clear_out_valid", 64'(bus.out_valid), 64'd0);
    fill_random();
    send_frame(1'b0);
    idle_and_drain();

    // Asynchronous reset in the middle of row 1 with an output held.
    bus.out_ready = 1'b0;
    fill_random();
    for (int c = 0; c < W; c++) send_beat(0, c);
    send_beat(1, 0);
    send_beat(1, 1);
    bus.in_valid = 1'b0;
    exp_q.delete();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_out_valid", 64'(bus.out_valid), 64'd0);
    check("async_reset_out_last", 64'(bus.out_last), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    fill_random();
    send_frame(1'b0);
    idle_and_drain();

    // Random frames with input gaps and random backpressure.
    rand_ready = 1'b1;
    for (int f = 0; f < 6; f++) begin
      fill_random();
      send_frame(1'b1);
    end
    bus.in_valid = 1'b0;
    rand_ready = 1'b0;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    idle_and_drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
